// File: rtl/rx_sync_ctrl.sv
// ============================================================================
// rx_sync_ctrl
// ----------------------------------------------------------------------------
// Word-synchronisation and link-quality controller for an 8b/10b receiver.
// It consumes per-symbol status flags from a 10b decoder. It acquires sync
// after COMMA_N good commas and tolerates isolated errors through a small
// error-level hysteresis. It also feeds the running disparity back to the
// decoder and keeps saturating error and loss-of-sync statistics.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   sym_vld    in   one-cycle strobe, qualifies the status inputs below
//   code_err   in   symbol is not a valid 10b code
//   disp_err   in   symbol arrived with the wrong running disparity
//   comma      in   symbol is K28.1 / K28.5 / K28.7
//   rdisp_nxt  in   decoder's running disparity after this symbol
//   clr_cnt    in   synchronous clear of err_cnt and los_cnt
//   rdisp      out  running disparity back to the decoder
//   sync_ok    out  link word-synchronised (state SYNC or SERR)
//   sym_ok     out  strobe: previous symbol good and received in sync
//   err_cnt    out  saturating count of bad symbols received in sync
//   los_cnt    out  saturating count of sync -> loss-of-sync transitions
//   state      out  encoded FSM state (LOS=0, CD=1, SYNC=2, SERR=3)
// ============================================================================
module rx_sync_ctrl #(
    parameter int ERR_W    = 16,
    parameter int GOOD_RUN = 4,
    parameter int COMMA_N  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_vld,
    input  logic             code_err,
    input  logic             disp_err,
    input  logic             comma,
    input  logic             rdisp_nxt,
    input  logic             clr_cnt,
    output logic             rdisp,
    output logic             sync_ok,
    output logic             sym_ok,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       los_cnt,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        LOS  = 3'd0,
        CD   = 3'd1,
        SYNC = 3'd2,
        SERR = 3'd3
    } state_t;

    localparam int CC_W = $clog2(COMMA_N + 1);
    localparam int GR_W = $clog2(GOOD_RUN + 1);

    state_t          st;
    logic [CC_W-1:0] comma_cnt;
    logic [1:0]      err_lvl;
    logic [GR_W-1:0] good_cnt;

    logic            sym_good;
    logic            sym_bad;
    logic            err_evt;
    logic            los_evt;
    logic [CC_W-1:0] cc_inc;
    logic [GR_W-1:0] gc_inc;

    function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    function automatic logic [7:0] sat_inc_los(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    assign sym_good = sym_vld & ~code_err & ~disp_err;
    assign sym_bad  = sym_vld & (code_err | disp_err);
    // sync_ok mirrors the registered state, so it qualifies "received in sync".
    assign err_evt  = sym_bad & sync_ok;
    assign los_evt  = sym_bad & (st == SERR) & (err_lvl == 2'd3);
    assign cc_inc   = comma_cnt + CC_W'(1);
    assign gc_inc   = good_cnt + GR_W'(1);
    assign state    = st;

    // ---- Synchronisation FSM, sync_ok registered alongside the state ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st        <= LOS;
            comma_cnt <= '0;
            err_lvl   <= '0;
            good_cnt  <= '0;
            sync_ok   <= 1'b0;
        end else if (sym_vld) begin
            case (st)
                LOS: begin
                    if (sym_good && comma) begin
                        if (COMMA_N <= 1) begin
                            st      <= SYNC;
                            sync_ok <= 1'b1;
                        end else begin
                            st        <= CD;
                            comma_cnt <= CC_W'(1);
                        end
                    end
                end
                CD: begin
                    if (sym_bad) begin
                        st        <= LOS;
                        comma_cnt <= '0;
                    end else if (comma) begin
                        if (cc_inc == CC_W'(COMMA_N)) begin
                            st        <= SYNC;
                            sync_ok   <= 1'b1;
                            comma_cnt <= '0;
                        end else begin
                            comma_cnt <= cc_inc;
                        end
                    end
                end
                SYNC: begin
                    if (sym_bad) begin
                        st       <= SERR;
                        err_lvl  <= 2'd1;
                        good_cnt <= '0;
                    end
                end
                SERR: begin
                    if (sym_bad) begin
                        good_cnt <= '0;
                        if (err_lvl == 2'd3) begin
                            st      <= LOS;
                            err_lvl <= '0;
                            sync_ok <= 1'b0;
                        end else begin
                            err_lvl <= err_lvl + 2'd1;
                        end
                    end else if (gc_inc == GR_W'(GOOD_RUN)) begin
                        // A full run of good symbols forgives one error level.
                        good_cnt <= '0;
                        err_lvl  <= err_lvl - 2'd1;
                        if (err_lvl == 2'd1) begin
                            st <= SYNC;
                        end
                    end else begin
                        good_cnt <= gc_inc;
                    end
                end
                default: begin
                    st        <= LOS;
                    comma_cnt <= '0;
                    err_lvl   <= '0;
                    good_cnt  <= '0;
                    sync_ok   <= 1'b0;
                end
            endcase
        end
    end

    // ---- Disparity feedback, symbol strobe and statistics counters ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdisp   <= 1'b0;
            sym_ok  <= 1'b0;
            err_cnt <= '0;
            los_cnt <= '0;
        end else begin
            sym_ok <= sym_good & sync_ok;

            // A disparity error still carries a valid code, so it resyncs rdisp.
            if (sym_vld && !code_err) begin
                rdisp <= rdisp_nxt;
            end

            // Clear first, then count a coincident event.
            if (clr_cnt) begin
                err_cnt <= err_evt ? ERR_W'(1) : '0;
            end else if (err_evt) begin
                err_cnt <= sat_inc_err(err_cnt);
            end

            if (clr_cnt) begin
                los_cnt <= los_evt ? 8'd1 : 8'd0;
            end else if (los_evt) begin
                los_cnt <= sat_inc_los(los_cnt);
            end
        end
    end

endmodule

// File: doc/rx_sync_ctrl.md
RX_SYNC_CTRL -- requirements
Module: rx_sync_ctrl

Interface
REQ-001 Parameter ERR_W, default 16: width of the bad-symbol counter err_cnt.
REQ-002 Parameter GOOD_RUN, default 4: number of consecutive good symbols that removes one error level.
REQ-003 Parameter COMMA_N, default 3: number of good commas needed to reach sync from loss-of-sync.
REQ-004 clk  in  1  single clock; every register updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sym_vld  in  1  one-cycle strobe; the status inputs below describe one decoded 10b symbol.
REQ-007 code_err  in  1  symbol is not a valid 10b code (OR of 6b and 4b sub-block code errors).
REQ-008 disp_err  in  1  symbol arrived with the wrong running disparity.
REQ-009 comma  in  1  symbol is a K28.1, K28.5 or K28.7 comma.
REQ-010 rdisp_nxt  in  1  running disparity after this symbol, as computed by the decoder (1 = positive).
REQ-011 clr_cnt  in  1  synchronous clear of err_cnt and los_cnt.
REQ-012 rdisp  out  1  running disparity fed back to the decoder rdispin inputs.
REQ-013 sync_ok  out  1  link word-synchronised.
REQ-014 sym_ok  out  1  one-cycle strobe: previous symbol was good and was received while sync_ok was 1.
REQ-015 err_cnt  out  ERR_W  saturating count of bad symbols received while sync_ok was 1.
REQ-016 los_cnt  out  8  saturating count of transitions from sync to loss-of-sync.
REQ-017 state  out  3  encoded FSM state, for debug.

Function
REQ-018 A symbol is "bad" when sym_vld=1 and (code_err|disp_err)=1, and "good" when sym_vld=1 and both flags are 0.
REQ-019 All state changes happen only on cycles with sym_vld=1; with sym_vld=0, every register except clear handling holds its value.
REQ-020 The FSM has these states and encodings: LOS=0, CD=1 (comma_cnt 1..COMMA_N-1), SYNC=2, SERR=3 (err_lvl 1..3).
REQ-021 LOS: a good comma moves to CD with comma_cnt=1 (or directly to SYNC if COMMA_N=1); any other symbol stays in LOS.
REQ-022 CD: a bad symbol moves to LOS and clears comma_cnt.
REQ-023 CD: a good comma increments comma_cnt; when the new count equals COMMA_N, the FSM moves to SYNC.
REQ-024 CD: a good non-comma symbol stays in CD with comma_cnt unchanged.
REQ-025 SYNC: a bad symbol moves to SERR with err_lvl=1 and good_cnt=0; a good symbol stays in SYNC.
REQ-026 SERR, bad symbol: err_lvl increments and good_cnt clears; if err_lvl was 3, the FSM moves to LOS instead and los_cnt increments, saturating at 255.
REQ-027 SERR, good symbol: good_cnt increments.
REQ-028 SERR, GOOD_RUN-th consecutive good symbol: err_lvl decrements and good_cnt clears; if err_lvl reaches 0, the FSM moves to SYNC.
REQ-029 sync_ok is a registered output, 1 exactly when state is SYNC or SERR; it takes its new value one cycle after the sym_vld edge that causes the transition.
REQ-030 rdisp loads rdisp_nxt on every sym_vld with code_err=0, including when disp_err=1 (this resynchronises disparity).
REQ-031 rdisp holds on code_err=1, because an invalid code gives no trustworthy disparity.
REQ-032 sym_ok is a registered strobe: it is 1 on the cycle after a good symbol sampled while sync_ok=1, and 0 otherwise.
REQ-033 err_cnt increments on each bad symbol sampled while sync_ok=1 and saturates at 2^ERR_W-1; it does not wrap.
REQ-034 clr_cnt=1 zeroes err_cnt and los_cnt on the next edge.
REQ-035 If clr_cnt coincides with an increment event, the counter loads 1 (clear, then count the event).
REQ-036 clr_cnt does not affect the FSM, rdisp or sync_ok.
REQ-037 The symbol that causes the SERR-to-LOS transition is still counted in err_cnt.
REQ-038 Latency from sym_vld to every output is exactly one clock; there is no back-pressure.

Reset
REQ-039 reset_n=0 asynchronously forces: state=LOS, comma_cnt=0, err_lvl=0, good_cnt=0, rdisp=0, sync_ok=0, sym_ok=0, err_cnt=0, los_cnt=0.
REQ-040 Reset asserted mid-operation, including in SERR, discards all progress.
REQ-041 After reset release, the first sym_vld edge is processed normally.

Verification
REQ-042 Sync acquire: after reset, send good commas K28.5 on 3 consecutive sym_vld cycles -> sync_ok=1 exactly one cycle after the 3rd comma; state=2.
REQ-043 Sync acquire with data between commas: send comma, 5 good data symbols, comma, comma -> sync_ok=1 after the 3rd comma; a code_err inserted before the 3rd comma -> state=0 and sync_ok stays 0.
REQ-044 Error recovery: in SYNC, send 1 bad symbol then 4 good symbols -> state goes 3 then 2; sync_ok stays 1 throughout; err_cnt=1; los_cnt=0.
REQ-045 Loss of sync: in SYNC, send 4 bad symbols separated by 3 good symbols each -> state=0, sync_ok=0, los_cnt=1, err_cnt=4.
REQ-046 Disparity and counters: send disp_err=1 with rdisp_nxt=1 -> rdisp=1; send code_err=1 with rdisp_nxt=0 -> rdisp stays 1; clr_cnt together with a bad symbol in sync -> err_cnt=1; force err_cnt to saturation -> it stays at 0xFFFF.
REQ-047 Asynchronous reset in SERR with err_lvl=2 -> all outputs are 0 immediately, before the next clock edge.
